factorial_seq: RTL and testbench

Parametrised iterative factorial engine: on a `start` pulse it latches an unsigned operand `n` and computes n! with a multi-cycle shift-add multiplier. It returns the result with a one-cycle `done` pulse and holds it until the next start. It is the generalised successor of the fixed 8-bit factorial unit: configurable operand and result widths, synchronous reset, a `busy` status, and optional overflow detection with saturation and early termination. It sits as a leaf compute block driven by a host FSM or testbench.

---
 rtl/factorial_pkg.sv | 14 +
 rtl/factorial_seq_shift_add_mul.sv | 78 +++++++
 rtl/factorial_seq.sv | 130 +++++++++++++
 tb/tb_factorial_seq.sv | 128 ++++++++++++
 4 files changed

// File: rtl/factorial_pkg.sv
// rtl/factorial_pkg.sv - shared FSM state type and default widths for factorial_seq
package factorial_pkg;

  localparam int FACT_WIDTH_DEF = 16;
  localparam int FACT_NW_DEF    = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_MUL   = 2'd2,
    S_DONE  = 2'd3
  } fact_state_t;

endpackage

// File: rtl/factorial_seq_shift_add_mul.sv
// rtl/factorial_seq_shift_add_mul.sv - multi-cycle shift-add multiplier, one multiplier bit per cycle; FACTORIAL_SEQ_OVF_EN adds overflow output
module shift_add_mul #(
  parameter int A_W = 16,
  parameter int B_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic [A_W-1:0] i_a,
  input  logic [B_W-1:0] i_b,
  output logic           o_busy,
  output logic           o_valid,
  output logic [A_W-1:0] o_product
`ifdef FACTORIAL_SEQ_OVF_EN
  ,
  output logic           o_ovf
`endif
);

  localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
`ifdef FACTORIAL_SEQ_OVF_EN
  localparam int P_W = A_W + B_W;
`else
  localparam int P_W = A_W;
`endif
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(B_W - 1);

  logic [A_W-1:0]   r_a;
  logic [B_W-1:0]   r_b;
  logic [P_W-1:0]   r_partial;
  logic [CNT_W-1:0] r_bit;
  logic             r_busy;
  logic [P_W-1:0]   w_addend;
  logic [P_W-1:0]   w_sum;

  // Term contributed by the multiplier bit under the counter this cycle
  always_comb begin
    w_addend = '0;
    if (r_b[r_bit]) begin
      w_addend = P_W'(r_a) << r_bit;
    end
  end

  // The sum is combinational so the caller can capture the product on the
  // final iteration edge without an extra cycle of latency.
  assign w_sum     = r_partial + w_addend;
  assign o_product = w_sum[A_W-1:0];
  assign o_valid   = r_busy && (r_bit == LAST_BIT);
  assign o_busy    = r_busy;
`ifdef FACTORIAL_SEQ_OVF_EN
  assign o_ovf     = o_valid && (|w_sum[P_W-1:A_W]);
`endif

  // Operand capture on load, then accumulate one partial product per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_partial <= '0;
      r_bit     <= '0;
      r_busy    <= 1'b0;
    end else if (i_load) begin
      r_a       <= i_a;
      r_b       <= i_b;
      r_partial <= '0;
      r_bit     <= '0;
      r_busy    <= 1'b1;
    end else if (r_busy) begin
      r_partial <= w_sum;
      if (r_bit == LAST_BIT) begin
        r_busy <= 1'b0;
      end else begin
        r_bit <= r_bit + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/factorial_seq.sv
// rtl/factorial_seq.sv - iterative n! engine with busy/done handshake; FACTORIAL_SEQ_OVF_EN enables overflow saturation
module factorial_seq
  import factorial_pkg::*;
#(
  parameter int WIDTH = FACT_WIDTH_DEF,
  parameter int N_W   = FACT_NW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_W-1:0]   Data_i,
  output logic [WIDTH-1:0] Out,
  output logic             done,
  output logic             busy,
  output logic             ovf
);

  fact_state_t      r_state;
  logic [WIDTH-1:0] r_acc;
  logic [N_W-1:0]   r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_done;
  logic             r_busy;

  logic             w_mul_load;
  logic             w_mul_busy;
  logic             w_mul_valid;
  logic [WIDTH-1:0] w_mul_product;
`ifdef FACTORIAL_SEQ_OVF_EN
  logic             w_mul_ovf;
  logic             r_ovf;
`endif

  // Multiplier is started from CHECK whenever another factor remains
  assign w_mul_load = (r_state == S_CHECK) && (r_cnt > N_W'(1));

  shift_add_mul #(
    .A_W (WIDTH),
    .B_W (N_W)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_mul_load),
    .i_a       (r_acc),
    .i_b       (r_cnt),
    .o_busy    (w_mul_busy),
    .o_valid   (w_mul_valid),
    .o_product (w_mul_product)
`ifdef FACTORIAL_SEQ_OVF_EN
    ,
    .o_ovf     (w_mul_ovf)
`endif
  );

  assign Out  = r_out;
  assign done = r_done;
  assign busy = r_busy;
`ifdef FACTORIAL_SEQ_OVF_EN
  assign ovf  = r_ovf;
`else
  assign ovf  = 1'b0;
`endif

  // Control FSM: owns accumulator, down-counter and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= WIDTH'(1);
      r_cnt   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef FACTORIAL_SEQ_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= WIDTH'(1);
            r_cnt   <= Data_i;
            r_busy  <= 1'b1;
`ifdef FACTORIAL_SEQ_OVF_EN
            r_ovf   <= 1'b0;
`endif
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_cnt <= N_W'(1)) begin
            r_out   <= r_acc;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          if (w_mul_busy && w_mul_valid) begin
`ifdef FACTORIAL_SEQ_OVF_EN
            if (w_mul_ovf) begin
              // Saturate and finish now; further factors cannot shrink it
              r_ovf   <= 1'b1;
              r_acc   <= '1;
              r_out   <= '1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_acc   <= w_mul_product;
              r_cnt   <= r_cnt - N_W'(1);
              r_state <= S_CHECK;
            end
`else
            r_acc   <= w_mul_product;
            r_cnt   <= r_cnt - N_W'(1);
            r_state <= S_CHECK;
`endif
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_seq.sv
// tb/tb_factorial_seq.sv - directed self-checking bench for factorial_seq
module tb_factorial_seq;

  localparam int WIDTH = 16;
  localparam int N_W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [N_W-1:0]   Data_i;
  logic [WIDTH-1:0] Out;
  logic             done;
  logic             busy;
  logic             ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  factorial_seq #(
    .WIDTH (WIDTH),
    .N_W   (N_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .Data_i (Data_i),
    .Out    (Out),
    .done   (done),
    .busy   (busy),
    .ovf    (ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one computation; cycle 1 is the first sample after the accepting edge
  task automatic run_fact(input string tag, input int n, input int exp_out,
                          input int exp_cyc, input bit exp_ovf, input int poke_at);
    int done_cyc;
    int busy_gaps;
    done_cyc  = -1;
    busy_gaps = 0;
    @(negedge clk);
    Data_i = N_W'(n);
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (!busy) busy_gaps++;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (poke_at > 0 && c == poke_at) begin
        start  = 1'b1;
        Data_i = 8'd6;
      end else if (poke_at > 0 && c == poke_at + 1) begin
        start  = 1'b0;
        Data_i = N_W'(n);
      end
    end
    check_eq({tag, "_done_cycle"}, done_cyc, exp_cyc);
    check_eq({tag, "_out"}, {16'd0, Out}, exp_out);
    check_eq({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    check_eq({tag, "_busy_gaps"}, busy_gaps, 0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, {31'd0, done}, 0);
    check_eq({tag, "_busy_after"}, {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    check_eq({tag, "_out_hold"}, {16'd0, Out}, exp_out);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    Data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out", {16'd0, Out}, 0);
    check_eq("rst_done", {31'd0, done}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_ovf", {31'd0, ovf}, 0);
    rst = 1'b0;

    run_fact("n5", 5, 120, 38, 1'b0, 0);
    run_fact("n0", 0, 1, 2, 1'b0, 0);
    run_fact("n1", 1, 1, 2, 1'b0, 0);
    run_fact("n8", 8, 16'h9D80, 65, 1'b0, 0);
`ifdef FACTORIAL_SEQ_OVF_EN
    run_fact("n9", 9, 16'hFFFF, 64, 1'b1, 0);
`else
    run_fact("n9", 9, 16'h8980, 74, 1'b0, 0);
`endif

    // Reset in the middle of an n=7 run
    @(negedge clk);
    Data_i = 8'd7;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", {31'd0, busy}, 0);
    check_eq("midrst_out", {16'd0, Out}, 0);
    check_eq("midrst_done", {31'd0, done}, 0);
    run_fact("after_rst_n3", 3, 6, 20, 1'b0, 0);

    // A start pulse while busy must be neither taken nor queued
    run_fact("ignore_n3", 3, 6, 20, 1'b0, 5);
    repeat (4) @(negedge clk);
    check_eq("ignore_no_requeue", {31'd0, busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
